mult8x8_seq_ctrl: RTL and testbench

Sequencer that computes an exact 8x8 unsigned product by time-multiplexing one external 4x4 multiplier core over four partial-product phases.
The product is sum(sub-product << shift), the same recursive split the team's multiplier generator uses.
The 4x4 core is external, so any generated exact or approximate 4x4 variant plugs in unchanged.
The block sits between a valid/ready operand source and a valid/ready result sink.

---
 rtl/mult_seq_pkg.sv | 38 +++
 rtl/mult_seq_nibble_sel.sv | 40 ++++
 rtl/mult8x8_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mult8x8_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
//   state_t    : controller states
//   phase_t    : partial-product phase (which nibble of a / b feeds the core)
//   operands_t : registered operand pair
//   SHIFT_TBL  : left shift applied to each phase's sub-product
package mult_seq_pkg;

   localparam int unsigned NIB_W   = 4;
   localparam int unsigned OPD_W   = 8;
   localparam int unsigned CORE_W  = 8;
   localparam int unsigned PROD_W  = 16;
   localparam int unsigned SHIFT_W = 4;
   localparam int unsigned PH_W    = 2;
   localparam int unsigned CNT_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      PH_LL = 2'd0,
      PH_LH = 2'd1,
      PH_HL = 2'd2,
      PH_HH = 2'd3
   } phase_t;

   typedef struct packed {
      logic [OPD_W-1:0] a;
      logic [OPD_W-1:0] b;
   } operands_t;

   // Indexed by phase_t: LL=0, LH=4, HL=4, HH=8
   localparam logic [3:0][SHIFT_W-1:0] SHIFT_TBL = '{4'd8, 4'd4, 4'd4, 4'd0};

endpackage

// File: rtl/mult_seq_nibble_sel.sv
// Phase -> core stimulus mux.
// Maps the running phase index (0..3) onto a partial-product phase, honouring
// the configured issue order, and selects the operand nibbles and shift.
//   i_phase_idx : running phase counter (0 = first issued phase)
//   i_en        : high while the core should be driven; outputs are 0 otherwise
//   i_ops       : registered operand pair
//   o_mul_a/b   : nibbles to the external 4x4 core
//   o_shift     : left shift for this phase's sub-product
module mult_seq_nibble_sel
   import mult_seq_pkg::*;
#(
   parameter bit ORDER_HI_FIRST = 1'b0
) (
   input  logic [PH_W-1:0]    i_phase_idx,
   input  logic               i_en,
   input  operands_t          i_ops,
   output logic [NIB_W-1:0]   o_mul_a,
   output logic [NIB_W-1:0]   o_mul_b,
   output logic [SHIFT_W-1:0] o_shift
);

   phase_t w_phase;
   logic   w_a_hi;
   logic   w_b_hi;

   always_comb begin
      // Hi-first order is the reverse sequence, i.e. 3 - idx.
      w_phase = ORDER_HI_FIRST ? phase_t'(~i_phase_idx) : phase_t'(i_phase_idx);
      w_a_hi  = (w_phase == PH_HL) || (w_phase == PH_HH);
      w_b_hi  = (w_phase == PH_LH) || (w_phase == PH_HH);
      o_mul_a = '0;
      o_mul_b = '0;
      if (i_en) begin
         o_mul_a = w_a_hi ? i_ops.a[7:4] : i_ops.a[3:0];
         o_mul_b = w_b_hi ? i_ops.b[7:4] : i_ops.b[3:0];
      end
      o_shift = SHIFT_TBL[w_phase];
   end

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller.
// Time-multiplexes an external 4x4 multiplier core over four partial-product
// phases and accumulates sum(sub-product << shift) into a 16-bit result.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_a / in_b operands
//   mul_a/mul_b, mul_p  : external core stimulus and product (MUL_LAT cycles)
//   out_valid/out_ready : result handshake, out_p product
//   busy                : high whenever the controller is not idle
module mult8x8_seq_ctrl
   import mult_seq_pkg::*;
#(
   parameter int unsigned MUL_LAT        = 0,
   parameter bit          ORDER_HI_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPD_W-1:0]  in_a,
   input  logic [OPD_W-1:0]  in_b,
   output logic [NIB_W-1:0]  mul_a,
   output logic [NIB_W-1:0]  mul_b,
   input  logic [CORE_W-1:0] mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_p,
   output logic              busy
);

   state_t             r_state;
   operands_t          r_ops;
   logic [PROD_W-1:0]  r_acc;
   logic [PH_W-1:0]    r_phase;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_valid;

   logic               w_core_en;
   logic [SHIFT_W-1:0] w_shift;
   logic [PROD_W-1:0]  w_acc_sum;
   logic               w_last;
   logic               w_accept;

   // Core is only driven while a product is in flight so it stays quiet otherwise.
   assign w_core_en = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

   mult_seq_nibble_sel #(
      .ORDER_HI_FIRST (ORDER_HI_FIRST)
   ) u_nibble_sel (
      .i_phase_idx (r_phase),
      .i_en        (w_core_en),
      .i_ops       (r_ops),
      .o_mul_a     (mul_a),
      .o_mul_b     (mul_b),
      .o_shift     (w_shift)
   );

   // Sub-product is zero-extended before shifting; the 16-bit sum cannot overflow.
   assign w_acc_sum = r_acc + (PROD_W'(mul_p) << w_shift);
   assign w_last    = (r_phase == PH_W'(3));

   // Accept in IDLE, or in DONE when the result leaves on the same edge.
   assign in_ready  = !rst && ((r_state == ST_IDLE) ||
                               ((r_state == ST_DONE) && out_ready));
   assign w_accept  = in_valid && in_ready;

   assign out_valid = r_out_valid;
   assign out_p     = r_acc;
   assign busy      = (r_state != ST_IDLE);

   // Controller FSM with accumulator and phase sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ops       <= '0;
         r_acc       <= '0;
         r_phase     <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ops   <= '{a: in_a, b: in_b};
                  r_acc   <= '0;
                  r_phase <= '0;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (MUL_LAT == 0) begin
                  // Combinational core: product is ready in the issue cycle.
                  r_acc   <= w_acc_sum;
                  r_phase <= r_phase + PH_W'(1);
                  if (w_last) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                  end
               end else begin
                  r_cnt   <= CNT_W'(MUL_LAT - 1);
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_acc   <= w_acc_sum;
                  r_phase <= r_phase + PH_W'(1);
                  if (w_last) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_accept) begin
                     // Back-to-back: next operation starts without an idle cycle.
                     r_ops   <= '{a: in_a, b: in_b};
                     r_acc   <= '0;
                     r_phase <= '0;
                     r_state <= ST_ISSUE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl.
// Instance 0: MUL_LAT=0, low-first order, combinational behavioural core.
// Instance 1: MUL_LAT=2, high-first order, two-stage delayed behavioural core.
module tb_mult8x8_seq_ctrl;

   localparam int unsigned LAT0 = 0;
   localparam int unsigned LAT1 = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [7:0]  in_a      [2];
   logic [7:0]  in_b      [2];
   logic [3:0]  mul_a     [2];
   logic [3:0]  mul_b     [2];
   logic [7:0]  mul_p     [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] out_p     [2];
   logic        busy      [2];

   mult8x8_seq_ctrl #(.MUL_LAT(LAT0), .ORDER_HI_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
      .mul_p(mul_p[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_p(out_p[0]), .busy(busy[0])
   );

   mult8x8_seq_ctrl #(.MUL_LAT(LAT1), .ORDER_HI_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1]), .in_b(in_b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
      .mul_p(mul_p[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_p(out_p[1]), .busy(busy[1])
   );

   // Behavioural 4x4 cores
   assign mul_p[0] = 8'(mul_a[0]) * 8'(mul_b[0]);

   logic [7:0] core1_d1, core1_d2;
   always @(posedge clk) begin
      core1_d1 <= 8'(mul_a[1]) * 8'(mul_b[1]);
      core1_d2 <= core1_d1;
   end
   assign mul_p[1] = core1_d2;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Nibble pair fed to the core for phase k (0=LL,1=LH,2=HL,3=HH)
   function automatic logic [7:0] nib_pair(input logic [7:0] a, input logic [7:0] b, input int k);
      logic [3:0] na, nb;
      na = (k >= 2) ? a[7:4] : a[3:0];
      nb = (k % 2 == 1) ? b[7:4] : b[3:0];
      return {na, nb};
   endfunction

   // One full operation with out_ready=1: latency, result, core stimulus, pulse width.
   task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
      logic [7:0] got_seq[$];
      logic [7:0] exp_seq[$];
      int per, lat, n, bad, k;
      per = (d == 0) ? int'(1 + LAT0) : int'(1 + LAT1);
      lat = 4 * per;
      for (int p = 0; p < 4; p++) begin
         k = (d == 1) ? 3 - p : p;
         repeat (per) exp_seq.push_back(nib_pair(a, b, k));
      end
      @(negedge clk);
      in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b; out_ready[d] = 1'b1;
      n = 0;
      while (!in_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[d]) begin
         check({name, "_accept_timeout"}, 32'(in_ready[d]), 32'd1);
         in_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_a[d] = 8'($urandom);
      in_b[d] = 8'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!out_valid[d]) got_seq.push_back({mul_a[d], mul_b[d]});
      end while (!out_valid[d] && n < 60);
      check({name, "_latency"}, 32'(n - 1), 32'(lat));
      check({name, "_out_p"}, 32'(out_p[d]), 32'(exp));
      check({name, "_core_idle_done"}, 32'({mul_a[d], mul_b[d]}), 32'd0);
      bad = (got_seq.size() == exp_seq.size()) ? 0 : 1000;
      for (int i = 0; i < got_seq.size() && i < exp_seq.size(); i++)
         if (got_seq[i] !== exp_seq[i]) bad++;
      check({name, "_core_seq_bad"}, 32'(bad), 32'd0);
      @(negedge clk);
      check({name, "_valid_pulse"}, 32'(out_valid[d]), 32'd0);
   endtask

   typedef struct {
      int          d;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;
      logic [7:0] ra, rb;

      vecs[0] = '{0, 8'h12, 8'h34, 16'h03A8, "basic_l0"};
      vecs[1] = '{0, 8'hFF, 8'hFF, 16'hFE01, "max_l0"};
      vecs[2] = '{0, 8'h00, 8'hFF, 16'h0000, "zero_l0"};
      vecs[3] = '{0, 8'h01, 8'h01, 16'h0001, "one_l0"};
      vecs[4] = '{1, 8'hA5, 8'h5A, 16'h3A02, "a5x5a_l2"};
      vecs[5] = '{1, 8'hFF, 8'hFF, 16'hFE01, "max_l2"};
      vecs[6] = '{1, 8'hFF, 8'h00, 16'h0000, "zero_l2"};
      vecs[7] = '{1, 8'h80, 8'h02, 16'h0100, "carry_l2"};

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; out_ready[d] = 1'b0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_in_ready_%0d", d), 32'(in_ready[d]), 32'd0);
         check($sformatf("rst_out_valid_%0d", d), 32'(out_valid[d]), 32'd0);
         check($sformatf("rst_out_p_%0d", d), 32'(out_p[d]), 32'd0);
         check($sformatf("rst_busy_%0d", d), 32'(busy[d]), 32'd0);
         check($sformatf("rst_mul_%0d", d), 32'({mul_a[d], mul_b[d]}), 32'd0);
         rst[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         check($sformatf("post_rst_in_ready_%0d", d), 32'(in_ready[d]), 32'd1);

      // Directed vectors
      for (int i = 0; i < 8; i++)
         run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      // Backpressure then back-to-back accept on instance 0
      @(negedge clk);
      in_valid[0] = 1'b1; in_a[0] = 8'h12; in_b[0] = 8'h34; out_ready[0] = 1'b0;
      check("bp_in_ready_idle", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid", 32'(out_valid[0]), 32'd1);
      in_valid[0] = 1'b1; in_a[0] = 8'h03; in_b[0] = 8'h07;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
         check("bp_hold_out_p", 32'(out_p[0]), 32'h03A8);
         check("bp_hold_in_ready", 32'(in_ready[0]), 32'd0);
      end
      @(negedge clk);
      out_ready[0] = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(negedge clk);
      check("b2b_valid_cleared", 32'(out_valid[0]), 32'd0);
      check("b2b_no_idle", 32'(busy[0]), 32'd1);
      n = 1;
      while (!out_valid[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_latency", 32'(n - 1), 32'd4);
      check("b2b_out_p", 32'(out_p[0]), 32'h0015);
      @(negedge clk);

      // Reset during phase 2 on instance 1
      @(negedge clk);
      in_valid[1] = 1'b1; in_a[1] = 8'h77; in_b[1] = 8'h88; out_ready[1] = 1'b1;
      check("mid_rst_in_ready", 32'(in_ready[1]), 32'd1);
      @(posedge clk);
      #1;
      in_valid[1] = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_rst_busy_before", 32'(busy[1]), 32'd1);
      rst[1] = 1'b1;
      #1;
      check("mid_rst_in_ready_forced", 32'(in_ready[1]), 32'd0);
      @(negedge clk);
      check("mid_rst_busy_cleared", 32'(busy[1]), 32'd0);
      rst[1] = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready_after", 32'(in_ready[1]), 32'd1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid[1]) seen = 1'b1;
      end
      check("mid_rst_no_result", 32'(seen), 32'd0);
      run_op(1, 8'h10, 8'h10, 16'h0100, "after_rst");

      // Randomized operands against a*b
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(1, ra, rb, 16'(ra) * 16'(rb), $sformatf("rand_l2_%0d", i));
      end
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(0, ra, rb, 16'(ra) * 16'(rb), $sformatf("rand_l0_%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
